// File: rtl/control_sequencer_if.sv
// Handshake/bus bundle between the control sequencer and its datapath.
// Latency: none, wires only. Backpressure: instruction fetch waits on I_ack.
// Ports: master = sequencer side (drives controls, reads IR/I_ack/Go/Ra_zero),
//        slave  = datapath/memory side (the mirror image).
interface control_sequencer_if #(
  parameter int PC_W   = 8,
  parameter int ALU_SW = 3
);
  logic [15:0]     IR;
  logic            I_ack;
  logic            Go;
  logic            Ra_zero;
  logic            I_req;
  logic            PC_clr;
  logic            PC_up;
  logic            PC_ld;
  logic [PC_W-1:0] PC_addr;
  logic            IR_ld;
  logic [7:0]      D_addr;
  logic            D_wr;
  logic            RF_s;
  logic            RF_W_en;
  logic [3:0]      RF_W_addr;
  logic [3:0]      RF_Ra_addr;
  logic [3:0]      RF_Rb_addr;
  logic [ALU_SW-1:0] Alu_s0;
  logic            Err;
  logic [3:0]      St;

  modport master (
    input  IR, I_ack, Go, Ra_zero,
    output I_req, PC_clr, PC_up, PC_ld, PC_addr, IR_ld, D_addr, D_wr,
           RF_s, RF_W_en, RF_W_addr, RF_Ra_addr, RF_Rb_addr, Alu_s0, Err, St
  );

  modport slave (
    output IR, I_ack, Go, Ra_zero,
    input  I_req, PC_clr, PC_up, PC_ld, PC_addr, IR_ld, D_addr, D_wr,
           RF_s, RF_W_en, RF_W_addr, RF_Ra_addr, RF_Rb_addr, Alu_s0, Err, St
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle instruction control sequencer: fetch, decode, execute FSM.
// Latency: fetch >= 1 cycle, decode 1, execute 1 (loads MEM_RD_LAT + 1).
// Backpressure: stalls in Fetch while I_ack=0; parks in Halt until Go.
// Ports: Clk, ResetN (async active-low), bus (control_sequencer_if.master).
module control_sequencer #(
  parameter int PC_W       = 8,
  parameter int MEM_RD_LAT = 1,
  parameter int ALU_SW     = 3
) (
  input logic                 Clk,
  input logic                 ResetN,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_STORE  = 4'd4,
    S_LOADA  = 4'd5,
    S_LOADB  = 4'd6,
    S_ALU    = 4'd7,
    S_JMP    = 4'd8,
    S_JZ     = 4'd9,
    S_HALT   = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  // LoadA runs while the counter walks from MEM_RD_LAT-1 down to 0.
  localparam logic [3:0] LAT_INIT = 4'(MEM_RD_LAT - 1);

  state_t     state;
  logic [3:0] lat_cnt;
  logic [3:0] opcode;
  logic [2:0] alu_code;

  assign opcode = bus.IR[15:12];

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state   <= S_INIT;
      lat_cnt <= '0;
    end else begin
      case (state)
        S_INIT:  state <= S_FETCH;
        S_FETCH: if (bus.I_ack) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            4'd0:                   state <= S_NOOP;
            4'd1:                   state <= S_STORE;
            4'd2: begin
              state   <= S_LOADA;
              lat_cnt <= LAT_INIT;
            end
            4'd3, 4'd4, 4'd8, 4'd9: state <= S_ALU;
            4'd5:                   state <= S_HALT;
            4'd6:                   state <= S_JMP;
            4'd7:                   state <= S_JZ;
            default:                state <= S_TRAP;
          endcase
        end
        S_LOADA: begin
          if (lat_cnt == 4'd0) state <= S_LOADB;
          else                 lat_cnt <= lat_cnt - 4'd1;
        end
        S_NOOP, S_STORE, S_LOADB, S_ALU, S_JMP, S_JZ: state <= S_FETCH;
        S_HALT:  if (bus.Go) state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;   // only reset leaves Trap
        default: state <= S_INIT;
      endcase
    end
  end

  always_comb begin
    case (opcode)
      4'd3:    alu_code = 3'd1;   // add
      4'd4:    alu_code = 3'd2;   // sub
      4'd8:    alu_code = 3'd3;   // and
      4'd9:    alu_code = 3'd4;   // or
      default: alu_code = 3'd0;
    endcase
  end

  // Outputs decode straight off the state register; IR fields are read live
  // because the datapath holds IR steady from IR_ld to the next Fetch. The
  // async reset forces state to Init, so reset outputs appear immediately.
  always_comb begin
    bus.I_req      = 1'b0;
    bus.PC_clr     = 1'b0;
    bus.PC_up      = 1'b0;
    bus.PC_ld      = 1'b0;
    bus.PC_addr    = '0;
    bus.IR_ld      = 1'b0;
    bus.D_addr     = 8'd0;
    bus.D_wr       = 1'b0;
    bus.RF_s       = 1'b0;
    bus.RF_W_en    = 1'b0;
    bus.RF_W_addr  = 4'd0;
    bus.RF_Ra_addr = 4'd0;
    bus.RF_Rb_addr = 4'd0;
    bus.Alu_s0     = '0;
    bus.Err        = 1'b0;
    bus.St         = state;
    case (state)
      S_INIT: bus.PC_clr = 1'b1;
      S_FETCH: begin
        bus.I_req = 1'b1;
        bus.IR_ld = bus.I_ack;
        bus.PC_up = bus.I_ack;
      end
      S_STORE: begin
        bus.D_addr     = bus.IR[7:0];
        bus.RF_Ra_addr = bus.IR[11:8];
        bus.D_wr       = 1'b1;
      end
      S_LOADA, S_LOADB: begin
        bus.D_addr    = bus.IR[11:4];
        bus.RF_s      = 1'b1;
        bus.RF_W_addr = bus.IR[3:0];
        bus.RF_W_en   = (state == S_LOADB);
      end
      S_ALU: begin
        bus.RF_Ra_addr = bus.IR[11:8];
        bus.RF_Rb_addr = bus.IR[7:4];
        bus.RF_W_addr  = bus.IR[3:0];
        bus.RF_W_en    = 1'b1;
        bus.Alu_s0     = ALU_SW'(alu_code);
      end
      S_JMP: begin
        bus.PC_ld   = 1'b1;
        bus.PC_addr = PC_W'(bus.IR[11:0]);
      end
      S_JZ: begin
        bus.RF_Ra_addr = bus.IR[11:8];
        bus.PC_addr    = PC_W'(bus.IR[11:0]);
        bus.PC_ld      = bus.Ra_zero;
      end
      S_TRAP: bus.Err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: table of per-cycle vectors plus reset sequences.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: I_ack stalls and Go/Halt handling are part of the vectors.
module tb_control_sequencer;

  logic Clk;
  logic ResetN;

  control_sequencer_if #(.PC_W(8), .ALU_SW(3)) bus ();

  control_sequencer #(.PC_W(8), .MEM_RD_LAT(3), .ALU_SW(3)) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus.master)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       i_req;
    logic       pc_clr;
    logic       pc_up;
    logic       pc_ld;
    logic [7:0] pc_addr;
    logic       ir_ld;
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic       rf_w_en;
    logic [3:0] w;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
    logic       err;
  } out_t;

  typedef struct {
    logic [15:0] ir;
    logic        ack;
    logic        go;
    logic        raz;
    logic [3:0]  st;
    out_t        exp;
  } vec_t;

  localparam out_t O_NONE  = '0;
  localparam out_t O_INIT  = out_t'{pc_clr: 1'b1, default: 0};
  localparam out_t O_FWAIT = out_t'{i_req: 1'b1, default: 0};
  localparam out_t O_FACK  = out_t'{i_req: 1'b1, ir_ld: 1'b1, pc_up: 1'b1, default: 0};
  localparam out_t O_LOADA = out_t'{d_addr: 8'hAB, rf_s: 1'b1, w: 4'd5, default: 0};
  localparam out_t O_LOADB = out_t'{d_addr: 8'hAB, rf_s: 1'b1, w: 4'd5, rf_w_en: 1'b1, default: 0};
  localparam out_t O_ERR   = out_t'{err: 1'b1, default: 0};

  out_t act;
  assign act = {bus.I_req, bus.PC_clr, bus.PC_up, bus.PC_ld, bus.PC_addr, bus.IR_ld,
                bus.D_addr, bus.D_wr, bus.RF_s, bus.RF_W_en, bus.RF_W_addr,
                bus.RF_Ra_addr, bus.RF_Rb_addr, bus.Alu_s0, bus.Err};

  int   checks = 0;
  int   passes = 0;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passes++;
  endtask

  task automatic add(input logic [15:0] ir, input logic ack, input logic go,
                     input logic raz, input logic [3:0] st, input out_t exp);
    vec_t v;
    v.ir = ir; v.ack = ack; v.go = go; v.raz = raz; v.st = st; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    ResetN      = 1'b0;
    bus.IR      = 16'h3214;
    bus.I_ack   = 1'b1;
    bus.Go      = 1'b1;
    bus.Ra_zero = 1'b0;

    // Add 0x3214: release, fetch, decode, Alu, back to Fetch (then I_ack stall)
    add(16'h3214, 1, 0, 0, 4'd0, O_INIT);
    add(16'h3214, 1, 0, 0, 4'd1, O_FACK);
    add(16'h3214, 1, 0, 0, 4'd2, O_NONE);
    add(16'h3214, 1, 0, 0, 4'd7, out_t'{rf_w_en: 1'b1, w: 4'd4, ra: 4'd2, rb: 4'd1, alu: 3'd1, default: 0});
    for (int i = 0; i < 4; i++) add(16'h3214, 0, 0, 0, 4'd1, O_FWAIT);
    // LoadA 0x2AB5 with three-cycle memory latency; Go in Decode is ignored
    add(16'h2AB5, 1, 0, 0, 4'd1, O_FACK);
    add(16'h2AB5, 1, 1, 0, 4'd2, O_NONE);
    for (int i = 0; i < 3; i++) add(16'h2AB5, 1, 0, 0, 4'd5, O_LOADA);
    add(16'h2AB5, 1, 0, 0, 4'd6, O_LOADB);
    // Jz 0x7340 taken, then not taken
    add(16'h7340, 1, 0, 1, 4'd1, O_FACK);
    add(16'h7340, 1, 0, 1, 4'd2, O_NONE);
    add(16'h7340, 1, 0, 1, 4'd9, out_t'{ra: 4'd3, pc_addr: 8'h40, pc_ld: 1'b1, default: 0});
    add(16'h7340, 1, 0, 0, 4'd1, O_FACK);
    add(16'h7340, 1, 0, 0, 4'd2, O_NONE);
    add(16'h7340, 1, 0, 0, 4'd9, out_t'{ra: 4'd3, pc_addr: 8'h40, default: 0});
    // Store 0x1A5C, Go ignored in Store
    add(16'h1A5C, 1, 0, 0, 4'd1, O_FACK);
    add(16'h1A5C, 1, 0, 0, 4'd2, O_NONE);
    add(16'h1A5C, 1, 1, 0, 4'd4, out_t'{d_addr: 8'h5C, ra: 4'hA, d_wr: 1'b1, default: 0});
    // Jmp 0x6123
    add(16'h6123, 1, 0, 0, 4'd1, O_FACK);
    add(16'h6123, 1, 0, 0, 4'd2, O_NONE);
    add(16'h6123, 1, 0, 0, 4'd8, out_t'{pc_ld: 1'b1, pc_addr: 8'h23, default: 0});
    // Noop 0x0000
    add(16'h0000, 1, 0, 0, 4'd1, O_FACK);
    add(16'h0000, 1, 0, 0, 4'd2, O_NONE);
    add(16'h0000, 1, 0, 0, 4'd3, O_NONE);
    // sub / and / or ALU selects
    add(16'h4567, 1, 0, 0, 4'd1, O_FACK);
    add(16'h4567, 1, 0, 0, 4'd2, O_NONE);
    add(16'h4567, 1, 0, 0, 4'd7, out_t'{rf_w_en: 1'b1, ra: 4'd5, rb: 4'd6, w: 4'd7, alu: 3'd2, default: 0});
    add(16'h8123, 1, 0, 0, 4'd1, O_FACK);
    add(16'h8123, 1, 0, 0, 4'd2, O_NONE);
    add(16'h8123, 1, 0, 0, 4'd7, out_t'{rf_w_en: 1'b1, ra: 4'd1, rb: 4'd2, w: 4'd3, alu: 3'd3, default: 0});
    add(16'h9456, 1, 0, 0, 4'd1, O_FACK);
    add(16'h9456, 1, 0, 0, 4'd2, O_NONE);
    add(16'h9456, 1, 0, 0, 4'd7, out_t'{rf_w_en: 1'b1, ra: 4'd4, rb: 4'd5, w: 4'd6, alu: 3'd4, default: 0});
    // Halt 0x5000: five idle cycles, Go pulse, then Fetch
    add(16'h5000, 1, 0, 0, 4'd1, O_FACK);
    add(16'h5000, 1, 0, 0, 4'd2, O_NONE);
    for (int i = 0; i < 5; i++) add(16'h5000, 1, 0, 0, 4'd10, O_NONE);
    add(16'h5000, 1, 1, 0, 4'd10, O_NONE);
    // Illegal opcode 0xC000: Trap sticks through Go
    add(16'hC000, 1, 0, 0, 4'd1, O_FACK);
    add(16'hC000, 1, 0, 0, 4'd2, O_NONE);
    add(16'hC000, 1, 0, 0, 4'd11, O_ERR);
    add(16'hC000, 1, 1, 0, 4'd11, O_ERR);
    add(16'hC000, 1, 0, 0, 4'd11, O_ERR);
    add(16'hC000, 1, 0, 0, 4'd11, O_ERR);

    // Held in reset with I_ack and Go active: nothing moves
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk); #1;
      chk($sformatf("reset_st%0d", i), 40'(bus.St), 40'd0);
      chk($sformatf("reset_out%0d", i), act, O_INIT);
    end

    foreach (tbl[i]) begin
      @(negedge Clk);
      ResetN      = 1'b1;
      bus.IR      = tbl[i].ir;
      bus.I_ack   = tbl[i].ack;
      bus.Go      = tbl[i].go;
      bus.Ra_zero = tbl[i].raz;
      #1;
      chk($sformatf("row%0d_st", i), 40'(bus.St), 40'(tbl[i].st));
      chk($sformatf("row%0d_out", i), act, tbl[i].exp);
    end

    // Reset clears Trap immediately
    @(negedge Clk);
    bus.Go = 1'b0;
    ResetN = 1'b0;
    #1;
    chk("trap_clr_st", 40'(bus.St), 40'd0);
    chk("trap_clr_out", act, O_INIT);

    // Run into LoadA, then assert reset between edges
    @(negedge Clk);
    ResetN    = 1'b1;
    bus.IR    = 16'h2AB5;
    bus.I_ack = 1'b1;
    #1;
    chk("rel_init_st", 40'(bus.St), 40'd0);
    @(negedge Clk); #1;
    chk("rel_fetch_st", 40'(bus.St), 40'd1);
    @(negedge Clk); #1;
    chk("rel_decode_st", 40'(bus.St), 40'd2);
    @(negedge Clk); #1;
    chk("rel_loada_st", 40'(bus.St), 40'd5);
    @(posedge Clk); #2;
    chk("loada2_st", 40'(bus.St), 40'd5);
    ResetN = 1'b0;
    #1;
    chk("midreset_st", 40'(bus.St), 40'd0);
    chk("midreset_out", act, O_INIT);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); #1;
      chk($sformatf("hold_wen%0d", i), 40'(bus.RF_W_en), 40'd0);
      chk($sformatf("hold_st%0d", i), 40'(bus.St), 40'd0);
    end

    // Init lasts exactly one cycle after release
    @(negedge Clk);
    ResetN = 1'b1;
    #1;
    chk("rel2_init_st", 40'(bus.St), 40'd0);
    chk("rel2_init_out", act, O_INIT);
    @(negedge Clk); #1;
    chk("rel2_fetch_st", 40'(bus.St), 40'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8: width of the program-counter jump target PC_addr.
REQ-002 SHALL have parameter MEM_RD_LAT, default 1, legal range 1..8: data-memory read latency in cycles.
REQ-003 SHALL have parameter ALU_SW, default 3: width of Alu_s0.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
- Clk  in  1  single clock, rising edge.
- ResetN  in  1  reset, asynchronous, active-low.
- IR  in  16  instruction register contents, opcode in IR[15:12].
- I_ack  in  1  instruction memory has the word ready.
- Go  in  1  resume pulse while halted.
- Ra_zero  in  1  register-file A-side read data equals zero.
- I_req  out  1  instruction fetch request.
- PC_clr, PC_up, PC_ld  out  1 each  clear PC, increment PC, load PC.
- PC_addr  out  PC_W  jump target.
- IR_ld  out  1  instruction load.
- D_addr  out  8  data address.
- D_wr  out  1  data write enable.
- RF_s  out  1  register-file write mux select (1 = memory).
- RF_W_en  out  1  register-file write enable.
- RF_W_addr, RF_Ra_addr, RF_Rb_addr  out  4 each  register addresses.
- Alu_s0  out  ALU_SW  ALU function select.
- Err  out  1  illegal opcode trap.
- St  out  4  current state code.

Function
REQ-005 SHALL encode states as: Init=0, Fetch=1, Decode=2, Noop=3, Store=4, LoadA=5, LoadB=6, Alu=7, Jmp=8, Jz=9, Halt=10, Trap=11, and drive St with the current state code.
REQ-006 SHALL drive every output to 0 in every state except where a rule below asserts it.
REQ-007 Init SHALL assert PC_clr=1 and go to Fetch.
REQ-008 Fetch SHALL assert I_req=1 and remain in Fetch while I_ack=0.
REQ-009 In the Fetch cycle with I_ack=1, the block SHALL assert IR_ld=1 and PC_up=1 for that cycle only and go to Decode.
REQ-010 Decode SHALL drive no outputs and SHALL branch on IR[15:12] as follows:
- 0 -> Noop
- 1 -> Store
- 2 -> LoadA
- 3, 4, 8, 9 -> Alu
- 5 -> Halt
- 6 -> Jmp
- 7 -> Jz
- 10..15 -> Trap
REQ-011 Noop SHALL go to Fetch.
REQ-012 Store SHALL assert D_addr=IR[7:0], RF_Ra_addr=IR[11:8] and D_wr=1, then go to Fetch.
REQ-013 LoadA SHALL assert D_addr=IR[11:4], RF_s=1 and RF_W_addr=IR[3:0] for exactly MEM_RD_LAT consecutive cycles, counted by an internal down-counter loaded on Decode.
REQ-014 LoadB SHALL assert the LoadA outputs plus RF_W_en=1 for one cycle, then go to Fetch.
REQ-015 Alu SHALL assert RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], RF_W_en=1 and RF_s=0, then go to Fetch.
REQ-016 Alu SHALL drive Alu_s0 from the opcode: 3 -> 1 (add), 4 -> 2 (sub), 8 -> 3 (and), 9 -> 4 (or), zero-extended or truncated to ALU_SW bits.
REQ-017 Jmp SHALL assert PC_ld=1 and PC_addr=IR[PC_W-1:0], zero-extended when PC_W>12, then go to Fetch.
REQ-018 Jz SHALL assert RF_Ra_addr=IR[11:8] and PC_addr=IR[PC_W-1:0], SHALL assert PC_ld=1 only when Ra_zero=1 in that cycle, and then go to Fetch.
REQ-019 Halt SHALL remain in Halt while Go=0 and go to Fetch on the first cycle with Go=1.
REQ-020 Go SHALL be ignored in every state other than Halt.
REQ-021 Trap SHALL assert Err=1 and remain in Trap until reset; Go SHALL have no effect in Trap.
REQ-022 IR SHALL be sampled combinationally in every state after Decode, and the bench SHALL hold IR stable from IR_ld until the next Fetch.
REQ-023 All state and counter registers SHALL update on the rising edge of Clk.
REQ-024 All outputs SHALL be Moore outputs of the current state, except the Fetch outputs (qualified by I_ack) and PC_ld in Jz (qualified by Ra_zero).

Reset
REQ-025 ResetN=0 SHALL force state Init and clear the latency counter immediately, without waiting for a Clk edge.
REQ-026 While ResetN=0 the block SHALL hold St=0, PC_clr=1 and every other output at 0.
REQ-027 Reset asserted mid-instruction (for example during LoadA or Halt) SHALL abort the instruction with no further D_wr, RF_W_en or PC_ld pulse.
REQ-028 After ResetN returns to 1, Init SHALL last exactly one cycle before Fetch.

Verification
REQ-029 Reset release, I_ack held at 1, IR=0x3214 -> St sequence 0,1,2,7,1; in the Alu cycle RF_Ra_addr=2, RF_Rb_addr=1, RF_W_addr=4, Alu_s0=1, RF_W_en=1.
REQ-030 MEM_RD_LAT=3, IR=0x2AB5 -> LoadA for 3 cycles with D_addr=0xAB and RF_W_en=0, then one LoadB cycle with RF_W_en=1 and RF_W_addr=5.
REQ-031 I_ack held low for 4 cycles in Fetch -> St=1 and I_req=1 throughout, IR_ld=0 and PC_up=0 throughout, then one IR_ld/PC_up pulse when I_ack=1.
REQ-032 IR=0x7340: with Ra_zero=1 -> PC_ld=1 and PC_addr=0x40; with Ra_zero=0 -> PC_ld=0; next state is Fetch in both cases.
REQ-033 IR=0x5000 with Go=0 for 5 cycles -> St stays 10; a Go pulse -> Fetch. IR=0xC000 -> St=11 and Err=1 that persist through a Go pulse and clear only on ResetN=0.
REQ-034 ResetN driven low between clock edges during LoadA -> St=0 and PC_clr=1 before the next edge, and no RF_W_en pulse follows.
